ext_mem_slave_model: RTL and testbench
======================================

Name: ext_mem_slave_model

Overview:
- Synthesizable two-channel off-chip memory model. It sits directly downstream of the HLS accelerator's master memory port (Mout_*) and produces that port's M_Rdata_ram/M_DataRdy responses.
- Replaces the ad-hoc behavioural memory logic in the simulation harness. Latency is cycle-exact and configurable, and the block has a preload port plus access statistics.
- Each channel is byte-wide with a per-access bit-size field and an independent latency FSM.

Parameters:
ADDR_W, 7, address bits per channel
MEMSIZE, 32, bytes of storage
BASE_ADDR, 0, first byte address answered by this slave
READ_DELAY, 2, cycles from read request to M_DataRdy (>=1)
WRITE_DELAY, 1, cycles from write request to M_DataRdy (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
Mout_oe_ram  in  2  per-channel read request
Mout_we_ram  in  2  per-channel write request
Mout_addr_ram  in  2*ADDR_W  channel c address at [c*ADDR_W +: ADDR_W]
Mout_Wdata_ram  in  16  channel c write byte at [c*8 +: 8]
Mout_data_ram_size  in  8  channel c access size in bits at [c*4 +: 4]
M_Rdata_ram  out  16  channel c read byte, valid only while M_DataRdy[c]
M_DataRdy  out  2  per-channel one-cycle completion strobe
load_en  in  1  preload write strobe
load_addr  in  ADDR_W  preload byte address (absolute, window-checked)
load_data  in  8  preload byte
proto_err  out  1  sticky: oe and we seen together on an idle channel
rd_count  out  32  completed reads, both channels
wr_count  out  32  completed writes, both channels

Behaviour:
- Reset (async, active-high) forces:
  - M_DataRdy=0, M_Rdata_ram=0, proto_err=0, rd_count=0, wr_count=0.
  - Both channel FSMs go to IDLE.
  - Storage contents are NOT cleared.
  - Reset mid-access aborts the access. No DataRdy is issued for it. A write that was already committed stays committed.
- In-window test: BASE_ADDR <= addr < BASE_ADDR+MEMSIZE. Index = addr-BASE_ADDR.
- Out-of-window requests are ignored entirely: no state change, no strobe, no count. Another slave answers them.
- Per-channel FSM states are IDLE, BUSY and DONE, with a latency counter cnt.
  - IDLE:
    - In-window oe=1, we=0 in cycle c: sample the storage byte at the edge ending cycle c, then go to BUSY if READ_DELAY>1, else DONE.
    - In-window we=1, oe=0: commit the masked write at that same edge, then go to BUSY or DONE by the same rule using WRITE_DELAY.
    - oe=1 and we=1 together: set proto_err, ignore the request, stay in IDLE.
  - BUSY: count cycles; reach DONE so that M_DataRdy[c] is high in exactly cycle c+DELAY.
  - DONE: M_DataRdy[c]=1 for that single cycle; for reads, M_Rdata_ram byte = sampled data. Go to IDLE.
  - Requests present during the DONE cycle are treated as the completing request still being held, and are ignored.
  - Minimum issue interval per channel is DELAY+1 cycles.
- M_Rdata_ram byte is 0 whenever M_DataRdy[c]=0, and for write completions.
- Write mask: bits = min(size,8); mask = (1<<bits)-1; new = (wdata & mask) | (old & ~mask). size=0 leaves the byte unchanged but still completes.
- Same-edge write conflicts:
  - Both channels writing the same index: channel 1 wins.
  - Channel write vs load_en at the same index: the channel write wins.
  - load_en with an out-of-window load_addr is dropped.
- Read and write to the same index on the same edge (either channel): the read returns the old byte.
- Counters increment on completion strobes: +1 or +2 per cycle depending on how many channels complete. They wrap modulo 2^32.
- proto_err clears only on reset.

Test Plan:
1. Preload idx 5 = 8'hA7. Ch0 oe, addr=5, held through DataRdy → M_DataRdy[0]=1 exactly 2 cycles after request, M_Rdata_ram[7:0]=A7 that cycle, 0 otherwise; rd_count=1.
2. Ch1 we, addr=3, wdata=FF, size=4, over preloaded 8'h50 → DataRdy[1] 1 cycle later; readback=5F; wr_count=1.
3. Both channels write idx 7 on the same edge (ch0=11, ch1=22), then read → 22. Both strobes are in the same cycle, so wr_count +2.
4. oe=we=1 on ch0 → proto_err=1, no DataRdy, counts unchanged. proto_err stays 1 through later valid accesses until reset.
5. Addr=BASE_ADDR+MEMSIZE (out of window) read → no strobe, and the FSM stays IDLE. Then an in-window read completes normally.
6. Read in flight with READ_DELAY=4, reset pulsed at cycle c+2 → no DataRdy. After reset, all outputs=0 and preloaded data is intact.

Source files
------------

// File: rtl/ext_mem_slave_model.sv
// Two-channel byte-wide memory slave with per-channel latency FSMs, preload port
// and completion statistics; answers the accelerator's Mout_* master port.
module ext_mem_slave_model #(
   parameter int unsigned ADDR_W      = 7,
   parameter int unsigned MEMSIZE     = 32,
   parameter int unsigned BASE_ADDR   = 0,
   parameter int unsigned READ_DELAY  = 2,
   parameter int unsigned WRITE_DELAY = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [1:0]          Mout_oe_ram,
   input  logic [1:0]          Mout_we_ram,
   input  logic [2*ADDR_W-1:0] Mout_addr_ram,
   input  logic [15:0]         Mout_Wdata_ram,
   input  logic [7:0]          Mout_data_ram_size,
   output logic [15:0]         M_Rdata_ram,
   output logic [1:0]          M_DataRdy,
   input  logic                load_en,
   input  logic [ADDR_W-1:0]   load_addr,
   input  logic [7:0]          load_data,
   output logic                proto_err,
   output logic [31:0]         rd_count,
   output logic [31:0]         wr_count
);

   localparam int unsigned IDX_W   = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned RD_LOAD = (READ_DELAY > 1) ? READ_DELAY - 2 : 0;
   localparam int unsigned WR_LOAD = (WRITE_DELAY > 1) ? WRITE_DELAY - 2 : 0;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state_q [2];
   state_t             state_d [2];
   logic [CNT_W-1:0]   cnt_q   [2];
   logic [CNT_W-1:0]   cnt_d   [2];
   logic [7:0]         samp_q  [2];
   logic [7:0]         samp_d  [2];
   logic [1:0]         is_rd_q, is_rd_d;
   logic [1:0]         rdy_q, rdy_d;
   logic [15:0]        rdata_q, rdata_d;
   logic               proto_err_q, proto_err_d;
   logic [31:0]        rd_count_q, rd_count_d;
   logic [31:0]        wr_count_q, wr_count_d;
   logic [7:0]         mem_q   [MEMSIZE];
   logic [7:0]         mem_d   [MEMSIZE];

   logic [31:0]        off     [2];
   logic [IDX_W-1:0]   idx     [2];
   logic [1:0]         in_win;
   logic [1:0]         wr_go;
   logic [7:0]         wr_val  [2];
   logic [31:0]        load_off;
   logic               load_ok;
   logic [1:0]         rd_inc, wr_inc;

   // Bit-size field to byte mask; sizes of 8 or more cover the whole byte.
   function automatic logic [7:0] size_mask(input logic [3:0] sz);
      if (sz >= 4'd8) return 8'hFF;
      return 8'((16'd1 << sz) - 16'd1);
   endfunction

   // Window decode and masked write data, per channel and for the preload port.
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         off[c]    = 32'(Mout_addr_ram[c*ADDR_W +: ADDR_W]) - BASE_ADDR;
         in_win[c] = off[c] < MEMSIZE;
         idx[c]    = IDX_W'(off[c]);
         wr_val[c] = (Mout_Wdata_ram[c*8 +: 8] & size_mask(Mout_data_ram_size[c*4 +: 4]))
                   | (mem_q[idx[c]] & ~size_mask(Mout_data_ram_size[c*4 +: 4]));
      end
      load_off = 32'(load_addr) - BASE_ADDR;
      load_ok  = load_en && (load_off < MEMSIZE);
   end

   // Channel FSMs, completion strobes and statistics.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      samp_d      = samp_q;
      is_rd_d     = is_rd_q;
      proto_err_d = proto_err_q;
      wr_go       = '0;
      rdy_d       = '0;
      rdata_d     = '0;
      rd_inc      = '0;
      wr_inc      = '0;
      for (int c = 0; c < 2; c++) begin
         unique case (state_q[c])
            IDLE: begin
               if (in_win[c]) begin
                  if (Mout_oe_ram[c] && Mout_we_ram[c]) begin
                     proto_err_d = 1'b1;
                  end else if (Mout_oe_ram[c]) begin
                     is_rd_d[c] = 1'b1;
                     samp_d[c]  = mem_q[idx[c]];
                     if (READ_DELAY > 1) begin
                        state_d[c] = BUSY;
                        cnt_d[c]   = CNT_W'(RD_LOAD);
                     end else begin
                        state_d[c] = DONE;
                     end
                  end else if (Mout_we_ram[c]) begin
                     is_rd_d[c] = 1'b0;
                     wr_go[c]   = 1'b1;
                     if (WRITE_DELAY > 1) begin
                        state_d[c] = BUSY;
                        cnt_d[c]   = CNT_W'(WR_LOAD);
                     end else begin
                        state_d[c] = DONE;
                     end
                  end
               end
            end
            BUSY: begin
               if (cnt_q[c] == '0) state_d[c] = DONE;
               else                cnt_d[c]   = cnt_q[c] - CNT_W'(1);
            end
            DONE:    state_d[c] = IDLE;
            default: state_d[c] = IDLE;
         endcase
         // Strobe and counters are registered on entry so they appear in the DONE cycle.
         if (state_d[c] == DONE && state_q[c] != DONE) begin
            rdy_d[c] = 1'b1;
            if (is_rd_d[c]) begin
               rdata_d[c*8 +: 8] = samp_d[c];
               rd_inc            = rd_inc + 2'd1;
            end else begin
               wr_inc = wr_inc + 2'd1;
            end
         end
      end
      rd_count_d = rd_count_q + 32'(rd_inc);
      wr_count_d = wr_count_q + 32'(wr_inc);
   end

   // Storage update: preload first, then channel 0, then channel 1 (last writer wins).
   always_comb begin
      mem_d = mem_q;
      if (load_ok) mem_d[IDX_W'(load_off)] = load_data;
      for (int c = 0; c < 2; c++) begin
         if (wr_go[c]) mem_d[idx[c]] = wr_val[c];
      end
   end

   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < 2; c++) begin
            state_q[c] <= IDLE;
            cnt_q[c]   <= '0;
            samp_q[c]  <= '0;
         end
         is_rd_q     <= '0;
         rdy_q       <= '0;
         rdata_q     <= '0;
         proto_err_q <= 1'b0;
         rd_count_q  <= '0;
         wr_count_q  <= '0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            state_q[c] <= state_d[c];
            cnt_q[c]   <= cnt_d[c];
            samp_q[c]  <= samp_d[c];
         end
         is_rd_q     <= is_rd_d;
         rdy_q       <= rdy_d;
         rdata_q     <= rdata_d;
         proto_err_q <= proto_err_d;
         rd_count_q  <= rd_count_d;
         wr_count_q  <= wr_count_d;
      end
   end

   assign M_DataRdy   = rdy_q;
   assign M_Rdata_ram = rdata_q;
   assign proto_err   = proto_err_q;
   assign rd_count    = rd_count_q;
   assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_ext_mem_slave_model.sv
// Directed bench for ext_mem_slave_model: a per-cycle vector table plus
// hand sequences for protocol errors, window edges, preload and reset abort.
module tb_ext_mem_slave_model;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  oe, we;
   logic [13:0] addr;
   logic [15:0] wdata;
   logic [7:0]  size;
   logic        load_en;
   logic [6:0]  load_addr;
   logic [7:0]  load_data;

   logic [15:0] rdata, rdata4;
   logic [1:0]  rdy, rdy4;
   logic        perr, perr4;
   logic [31:0] rdc, wrc, rdc4, wrc4;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   ext_mem_slave_model u_dut (
      .clock(clock), .reset(reset),
      .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
      .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
      .M_Rdata_ram(rdata), .M_DataRdy(rdy),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .proto_err(perr), .rd_count(rdc), .wr_count(wrc)
   );

   // Second instance with a longer read latency for the reset-abort case.
   ext_mem_slave_model #(.READ_DELAY(4)) u_dut4 (
      .clock(clock), .reset(reset),
      .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
      .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
      .M_Rdata_ram(rdata4), .M_DataRdy(rdy4),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .proto_err(perr4), .rd_count(rdc4), .wr_count(wrc4)
   );

   typedef struct {
      logic [1:0]  oe;
      logic [1:0]  we;
      logic [6:0]  a0;
      logic [6:0]  a1;
      logic [7:0]  w0;
      logic [7:0]  w1;
      logic [3:0]  s0;
      logic [3:0]  s1;
      logic [1:0]  rdy;
      logic [15:0] rd;
   } vec_t;

   localparam int NV = 26;
   vec_t vt [NV];

   function automatic vec_t mk(input logic [1:0] o, input logic [1:0] w,
                               input logic [6:0] a0, input logic [6:0] a1,
                               input logic [7:0] w0, input logic [7:0] w1,
                               input logic [3:0] s0, input logic [3:0] s1,
                               input logic [1:0] r, input logic [15:0] d);
      vec_t v;
      v.oe = o; v.we = w; v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
      v.s0 = s0; v.s1 = s1; v.rdy = r; v.rd = d;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [1:0] o, input logic [1:0] w,
                        input logic [6:0] a0, input logic [6:0] a1,
                        input logic [7:0] w0, input logic [7:0] w1,
                        input logic [3:0] s0, input logic [3:0] s1);
      oe = o; we = w; addr = {a1, a0}; wdata = {w1, w0}; size = {s1, s0};
   endtask

   task automatic idle();
      drive(2'b00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0);
   endtask

   task automatic preload(input logic [6:0] a, input logic [7:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      tick();
      load_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
      idle();

      // Reset state
      tick(); tick();
      chk("rst rdy", 32'(rdy), 32'h0);
      chk("rst rdata", 32'(rdata), 32'h0);
      chk("rst perr", 32'(perr), 32'h0);
      chk("rst rdc", rdc, 32'h0);
      chk("rst wrc", wrc, 32'h0);
      reset = 1'b0;
      tick();

      preload(7'd5, 8'hA7);
      preload(7'd3, 8'h50);

      //         oe     we     a0    a1    w0     w1     s0    s1    rdy    rdata
      vt[0]  = mk(2'b01, 2'b00, 7'd5, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b00, 16'h0000);
      vt[1]  = mk(2'b01, 2'b00, 7'd5, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b01, 16'h00A7);
      vt[2]  = mk(2'b01, 2'b00, 7'd5, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b00, 16'h0000);
      vt[3]  = mk(2'b00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b00, 16'h0000);
      vt[4]  = mk(2'b00, 2'b10, 7'd0, 7'd3, 8'h00, 8'hFF, 4'd0, 4'd4, 2'b10, 16'h0000);
      vt[5]  = mk(2'b00, 2'b10, 7'd0, 7'd3, 8'h00, 8'hFF, 4'd0, 4'd4, 2'b00, 16'h0000);
      vt[6]  = mk(2'b00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b00, 16'h0000);
      vt[7]  = mk(2'b10, 2'b00, 7'd0, 7'd3, 8'h00, 8'h00, 4'd0, 4'd0, 2'b00, 16'h0000);
      vt[8]  = mk(2'b00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b10, 16'h5F00);
      vt[9]  = mk(2'b00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b00, 16'h0000);
      vt[10] = mk(2'b00, 2'b11, 7'd7, 7'd7, 8'h11, 8'h22, 4'd8, 4'd8, 2'b11, 16'h0000);
      vt[11] = mk(2'b00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b00, 16'h0000);
      vt[12] = mk(2'b01, 2'b00, 7'd7, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b00, 16'h0000);
      vt[13] = mk(2'b00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b01, 16'h0022);
      vt[14] = mk(2'b00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b00, 16'h0000);
      vt[15] = mk(2'b01, 2'b10, 7'd7, 7'd7, 8'h00, 8'h33, 4'd0, 4'd8, 2'b10, 16'h0000);
      vt[16] = mk(2'b00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b01, 16'h0022);
      vt[17] = mk(2'b00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b00, 16'h0000);
      vt[18] = mk(2'b01, 2'b00, 7'd7, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b00, 16'h0000);
      vt[19] = mk(2'b00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b01, 16'h0033);
      vt[20] = mk(2'b00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b00, 16'h0000);
      vt[21] = mk(2'b00, 2'b01, 7'd5, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b01, 16'h0000);
      vt[22] = mk(2'b00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b00, 16'h0000);
      vt[23] = mk(2'b01, 2'b00, 7'd5, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b00, 16'h0000);
      vt[24] = mk(2'b00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b01, 16'h00A7);
      vt[25] = mk(2'b00, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0, 2'b00, 16'h0000);

      for (int i = 0; i < NV; i++) begin
         drive(vt[i].oe, vt[i].we, vt[i].a0, vt[i].a1, vt[i].w0, vt[i].w1, vt[i].s0, vt[i].s1);
         tick();
         chk($sformatf("vec%0d rdy", i), 32'(rdy), 32'(vt[i].rdy));
         chk($sformatf("vec%0d rdata", i), 32'(rdata), 32'(vt[i].rd));
      end
      chk("table rdc", rdc, 32'd6);
      chk("table wrc", wrc, 32'd5);
      chk("table perr", 32'(perr), 32'h0);

      // oe and we together: sticky error, no strobe, counts unchanged
      drive(2'b01, 2'b01, 7'd2, 7'd0, 8'hEE, 8'h00, 4'd8, 4'd0);
      tick(); idle();
      chk("perr set", 32'(perr), 32'h1);
      chk("perr rdy0", 32'(rdy), 32'h0);
      tick();
      chk("perr rdy1", 32'(rdy), 32'h0);
      tick();
      chk("perr rdy2", 32'(rdy), 32'h0);
      chk("perr rdc", rdc, 32'd6);
      chk("perr wrc", wrc, 32'd5);
      drive(2'b01, 2'b00, 7'd5, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0);
      tick(); idle(); tick();
      chk("perr read rdy", 32'(rdy), 32'h1);
      chk("perr read data", 32'(rdata), 32'h00A7);
      chk("perr sticky", 32'(perr), 32'h1);
      tick();

      // Out-of-window read followed immediately by an in-window read
      drive(2'b01, 2'b00, 7'd32, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0);
      tick();
      chk("oow rdy c+1", 32'(rdy), 32'h0);
      drive(2'b01, 2'b00, 7'd3, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0);
      tick(); idle();
      chk("oow rdy c+2", 32'(rdy), 32'h0);
      tick();
      chk("post-oow rdy", 32'(rdy), 32'h1);
      chk("post-oow data", 32'(rdata), 32'h005F);
      tick();
      chk("oow rdc", rdc, 32'd8);

      // Out-of-window preload dropped; channel write beats preload at same index
      preload(7'd8, 8'h3C);
      preload(7'd40, 8'hFF);
      load_en = 1'b1; load_addr = 7'd9; load_data = 8'hAA;
      drive(2'b00, 2'b01, 7'd9, 7'd0, 8'hBB, 8'h00, 4'd8, 4'd0);
      tick(); idle(); load_en = 1'b0;
      chk("ld-vs-wr rdy", 32'(rdy), 32'h1);
      tick();
      drive(2'b01, 2'b00, 7'd8, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0);
      tick(); idle(); tick();
      chk("oow load data", 32'(rdata), 32'h003C);
      tick();
      drive(2'b01, 2'b00, 7'd9, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0);
      tick(); idle(); tick();
      chk("ld-vs-wr data", 32'(rdata), 32'h00BB);
      tick();
      chk("final rdc", rdc, 32'd10);
      chk("final wrc", wrc, 32'd6);

      // READ_DELAY=4 instance: exact latency, then reset mid-access
      repeat (6) tick();
      drive(2'b01, 2'b00, 7'd5, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0);
      tick(); idle();
      for (int k = 1; k < 4; k++) begin
         chk($sformatf("d4 rdy c+%0d", k), 32'(rdy4), 32'h0);
         tick();
      end
      chk("d4 rdy c+4", 32'(rdy4), 32'h1);
      chk("d4 data c+4", 32'(rdata4), 32'h00A7);
      tick(); tick();
      drive(2'b01, 2'b00, 7'd5, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0);
      tick(); idle();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort rdy", 32'(rdy4), 32'h0);
      chk("abort rdata", 32'(rdata4), 32'h0);
      chk("abort perr4", 32'(perr4), 32'h0);
      chk("abort perr", 32'(perr), 32'h0);
      chk("abort rdc4", rdc4, 32'h0);
      chk("abort wrc4", wrc4, 32'h0);
      chk("abort rdc", rdc, 32'h0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("abort quiet%0d", k), 32'(rdy4), 32'h0);
      end
      drive(2'b01, 2'b00, 7'd5, 7'd0, 8'h00, 8'h00, 4'd0, 4'd0);
      tick(); idle();
      repeat (3) tick();
      chk("intact rdy", 32'(rdy4), 32'h1);
      chk("intact data", 32'(rdata4), 32'h00A7);
      tick();
      chk("intact rdc4", rdc4, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
